// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a non-showahead FIFO into a valid/ready stream with fixed-length sop/eop framing.
// Defining FIFO_READER_PKT_CNT_EN adds pkt_cnt_o, a wrapping count of delivered packets.
module fifo_stream_reader #(
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 4,
    parameter int PKT_LEN       = 8,
    parameter bit WAIT_FULL_PKT = 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    input  logic              fifo_empty_i,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o
`ifdef FIFO_READER_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt_o
`endif
);
    localparam int CW = $clog2(PKT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(PKT_LEN - 1);
    typedef enum logic {IDLE, READ} state_t;
    state_t            state;
    logic [CW-1:0]     rd_idx, out_idx;
    logic [1:0]        buf_cnt, occ_nxt;
    logic              inflight, pop, start;
    logic [DWIDTH-1:0] buf1;
    assign valid_o      = buf_cnt != 2'd0 && !srst_i;
    assign pop          = valid_o && ready_i;
    assign occ_nxt      = buf_cnt + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rdreq_o = state == READ && !fifo_empty_i && occ_nxt < 2'd2 && !srst_i;
    assign start        = WAIT_FULL_PKT ? fifo_usedw_i >= (AWIDTH+1)'(PKT_LEN) : !fifo_empty_i;
    assign sop_o        = valid_o && out_idx == '0;
    assign eop_o        = valid_o && out_idx == LAST;
    // data_o is the skid head; buf1 holds the second word when the consumer stalls
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state    <= IDLE;
            rd_idx   <= '0;
            out_idx  <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
            data_o   <= '0;
        end else begin
            inflight <= fifo_rdreq_o;
            buf_cnt  <= occ_nxt;
            if (state == IDLE && start)
                state <= READ;
            if (fifo_rdreq_o) begin
                rd_idx <= rd_idx == LAST ? '0 : rd_idx + CW'(1);
                if (rd_idx == LAST)
                    state <= IDLE;
            end
            if (pop) begin
                out_idx <= out_idx == LAST ? '0 : out_idx + CW'(1);
                data_o  <= buf_cnt == 2'd1 ? fifo_q_i : buf1;
            end else if (inflight && buf_cnt == 2'd0)
                data_o <= fifo_q_i;
            if (inflight && (pop ? buf_cnt == 2'd2 : buf_cnt != 2'd0))
                buf1 <= fifo_q_i;
        end
    end
`ifdef FIFO_READER_PKT_CNT_EN
    always_ff @(posedge clk_i) begin
        if (srst_i)
            pkt_cnt_o <= '0;
        else if (pop && eop_o)
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: two readers (PKT_LEN=8 waiting for full packets, PKT_LEN=4 reading eagerly)
// driven by directed and random stimulus, each against a queue-level model of its FIFO and stream.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        srst = 1'b1, ready = 1'b0;
    logic [31:0] fifo_q [2];
    logic        fifo_empty [2];
    logic [4:0]  usedw [2];
    logic        rdreq [2], valid [2], sop [2], eop [2];
    logic [31:0] data [2];
`ifdef FIFO_READER_PKT_CNT_EN
    logic [15:0] pkt_cnt [2];
`endif
    fifo_stream_reader #(.DWIDTH(32), .AWIDTH(4), .PKT_LEN(8), .WAIT_FULL_PKT(1)) dut0 (
        .clk_i(clk), .srst_i(srst), .fifo_q_i(fifo_q[0]), .fifo_empty_i(fifo_empty[0]),
        .fifo_usedw_i(usedw[0]), .fifo_rdreq_o(rdreq[0]), .data_o(data[0]), .valid_o(valid[0]),
        .ready_i(ready), .sop_o(sop[0]), .eop_o(eop[0])
`ifdef FIFO_READER_PKT_CNT_EN
        , .pkt_cnt_o(pkt_cnt[0])
`endif
    );
    fifo_stream_reader #(.DWIDTH(32), .AWIDTH(4), .PKT_LEN(4), .WAIT_FULL_PKT(0)) dut1 (
        .clk_i(clk), .srst_i(srst), .fifo_q_i(fifo_q[1]), .fifo_empty_i(fifo_empty[1]),
        .fifo_usedw_i(usedw[1]), .fifo_rdreq_o(rdreq[1]), .data_o(data[1]), .valid_o(valid[1]),
        .ready_i(ready), .sop_o(sop[1]), .eop_o(eop[1])
`ifdef FIFO_READER_PKT_CNT_EN
        , .pkt_cnt_o(pkt_cnt[1])
`endif
    );
    // FIFO contents and words already read (in flight or buffered) as monotonic ring pointers
    logic [31:0] fmem [2][32];
    logic [31:0] emem [2][4];
    int          fwp [2], frp [2], ewp [2], erp [2], rcnt [2], opos [2], npkt [2];
    logic        rd_s [2], wr_s [2];
    logic [31:0] wd_s [2];
    int          n_cmp = 0, n_bad = 0;
    logic        v0, s0, e0, r0, pop0;
    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", name, i, $time, act, exp);
        end
    endtask
    task automatic step(input logic rst, input logic rdy, input logic wr);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rd_s[i]) begin
                fifo_q[i] = fmem[i][frp[i] % 32];
                frp[i]++;
            end
            if (wr_s[i]) begin
                fmem[i][fwp[i] % 32] = wd_s[i];
                fwp[i]++;
            end
            fifo_empty[i] = fwp[i] == frp[i];
            usedw[i] = 5'(fwp[i] - frp[i]);
        end
        srst = rst;
        ready = rdy;
        #1;
        for (int i = 0; i < 2; i++) begin
            int plen, esz, nbuf;
            logic ev, p, ok;
            plen = i == 0 ? 8 : 4;
            esz = ewp[i] - erp[i];
            nbuf = esz - (rd_s[i] ? 1 : 0);
            ev = !rst && nbuf > 0;
            p = ev && rdy;
            chk("valid", i, valid[i], ev);
            if (ev) begin
                chk("data", i, data[i], emem[i][erp[i] % 4]);
                chk("sop", i, sop[i], opos[i] == 0);
                chk("eop", i, eop[i], opos[i] == plen - 1);
            end
`ifdef FIFO_READER_PKT_CNT_EN
            if (!rst)
                chk("pkt_cnt", i, pkt_cnt[i], 32'(npkt[i] % 65536));
`endif
            if (rst || rcnt[i] % plen != 0) begin
                chk("rdreq", i, rdreq[i], !rst && !fifo_empty[i] && esz - p < 2);
                if (i == 0 && !rst)
                    chk("starved", i, fifo_empty[i], 0);
            end else if (rdreq[i] !== 1'b0) begin
                ok = !fifo_empty[i] && esz - p < 2 && (i != 0 || usedw[i] >= 5'd8);
                chk("rdreq_start", i, ok, 1);
            end
            if (p) begin
                if (opos[i] == plen - 1)
                    npkt[i]++;
                erp[i]++;
                opos[i] = (opos[i] + 1) % plen;
            end
            if (rdreq[i] === 1'b1 && !rst) begin
                emem[i][ewp[i] % 4] = fmem[i][frp[i] % 32];
                ewp[i]++;
                rcnt[i]++;
            end
            if (rst) begin
                erp[i] = ewp[i];
                opos[i] = 0;
                rcnt[i] = 0;
                npkt[i] = 0;
            end
            rd_s[i] = rdreq[i] === 1'b1 && !rst;
            wr_s[i] = wr && usedw[i] < 5'd16;
            wd_s[i] = $urandom;
        end
        v0 = valid[0];
        s0 = sop[0];
        e0 = eop[0];
        r0 = rdreq[0];
        pop0 = valid[0] && rdy;
    endtask
    initial begin
        int any_rd, nv, ns, ne, first, last, np, npp;
        logic seen, done, rst, wr, rdy;
        int wmod;
        for (int i = 0; i < 2; i++) begin
            fwp[i] = 0; frp[i] = 0; ewp[i] = 0; erp[i] = 0;
            rcnt[i] = 0; opos[i] = 0; npkt[i] = 0;
            rd_s[i] = 0; wr_s[i] = 0; wd_s[i] = 0;
            fifo_q[i] = 0; fifo_empty[i] = 1; usedw[i] = 0;
        end
        // reset held while the FIFO fills with 5 words
        for (int c = 0; c < 5; c++) step(1, 1, 1);
        step(1, 1, 0);
        chk("rst_rdreq", 0, r0, 0);
        chk("rst_valid", 0, v0, 0);
        step(0, 1, 0);
        chk("post_rst_rdreq", 0, r0, 0);
        chk("post_rst_valid", 0, v0, 0);
        // 7 words: a full-packet reader must not start
        any_rd = 0;
        for (int c = 0; c < 8; c++) begin
            step(0, 1, c < 2);
            any_rd += r0;
        end
        chk("seven_no_rdreq", 0, any_rd, 0);
        chk("seven_usedw", 0, usedw[0], 7);
        nv = 0; ns = 0; ne = 0; first = -1; last = -1;
        for (int c = 0; c < 18; c++) begin
            step(0, 1, c == 0);
            if (v0) begin
                nv++;
                ns += s0;
                ne += e0;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("pkt_valid_cycles", 0, nv, 8);
        chk("pkt_contiguous", 0, last - first, 7);
        chk("pkt_sop_count", 0, ns, 1);
        chk("pkt_eop_count", 0, ne, 1);
`ifdef FIFO_READER_PKT_CNT_EN
        chk("pkt_cnt_one", 0, pkt_cnt[0], 1);
`endif
        // reset after the third pop of a packet
        for (int c = 0; c < 8; c++) step(0, 0, 1);
        np = 0;
        for (int c = 0; c < 40 && np < 3; c++) begin
            step(0, 1, 0);
            np += pop0;
        end
        chk("three_pops", 0, np, 3);
        step(1, 1, 0);
        for (int c = 0; c < 8; c++) step(0, 0, 1);
        seen = 0; done = 0; npp = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            step(0, 1, 0);
            if (v0 && !seen) begin
                chk("sop_after_rst", 0, s0, 1);
                seen = 1;
            end
            if (pop0) npp++;
            if (pop0 && e0) done = 1;
        end
        chk("eop_seen", 0, done, 1);
        chk("eop_after_8", 0, npp, 8);
        // backpressure with 16 words and ready pattern 1,0,0,1,0,1
        for (int c = 0; c < 150; c++) step(0, (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 5), c < 16);
        // sparse writes: one word every 3 cycles
        for (int c = 0; c < 90; c++) step(0, 1, c % 3 == 0);
        // random traffic with varying write density and occasional resets
        wmod = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) wmod = $urandom_range(1, 4);
            rst = $urandom_range(0, 499) == 0;
            rdy = $urandom_range(0, 3) != 0;
            wr = $urandom_range(0, wmod - 1) == 0;
            step(rst, rdy, wr);
        end
        for (int c = 0; c < 40; c++) step(0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
